dct_transpose_buffer: RTL
=========================

// Module: dct_transpose_buffer
// PURPOSE
//  Row-to-column transpose buffer between the row (1st-pass) 1D-DCT stage and the
//  column (2nd-pass) 1D-DCT stage of the 2D-DCT preprocessing pipeline.
//  Collects eight 8-coefficient row results into an 8x8 block, then emits the
//  block column by column. Two banks (ping-pong) let the next block be written
//  while the current one is read out.
// PARAMETERS
//  DATA_W  12  signed coefficient width, input and output
// PORTS
//  i_clk       in   1         clock, all state on rising edge
//  i_rst       in   1         asynchronous, active-high reset
//  i_valid     in   1         one row result present on i_data0..7 (one-cycle beat)
//  i_data0..7  in   DATA_W    signed row coefficients, index = column position
//  i_ready     in   1         downstream column stage accepts o_data this cycle
//  o_valid     out  1         one column present on o_data0..7
//  o_data0..7  out  DATA_W    signed column; o_dataK = block[row K][column o_col]
//  o_col       out  3         column index of current output beat (0..7)
//  o_last      out  1         o_valid beat carries column 7 of the block
//  o_overflow  out  1         sticky: a row was dropped because no bank was free
// BEHAVIOUR
//  Reset: async, all outputs 0, both banks empty, write/read pointers 0, bank 0 selected.
//  Storage: 2 banks x 8 rows x 8 x DATA_W registers, plus per-bank full flag.
//  Write side:
//  - i_valid with target bank not full: store row at wr_row, wr_row+1.
//  - Write at wr_row==7: set full flag, toggle wr_bank, wr_row <= 0.
//  - i_valid with target bank full: row dropped, wr_row unchanged, o_overflow <= 1.
//    o_overflow is cleared only by reset.
//  - A bank freed by the final read handshake in the same cycle counts as free,
//    so the write is accepted.
//  Read side:
//  - o_valid = full flag of rd_bank.
//  - o_data0..7 are muxed from rd_bank, column rd_col, and stay stable while
//    o_valid && !i_ready.
//  - Handshake (o_valid && i_ready): rd_col+1.
//  - Handshake at rd_col==7 (o_last=1): clear bank full, toggle rd_bank, rd_col <= 0.
//  - o_col = rd_col. o_last = o_valid && rd_col==7.
//  - If the other bank is already full after a block handshake, o_valid stays
//    high and column 0 of that block follows on the next cycle.
//  Latency: 8th row written at edge t; o_valid=1 with column 0 in the cycle after edge t.
//    With i_ready=1, columns stream on 8 consecutive cycles.
//  Throughput: sustained one row/cycle in and one column/cycle out without loss.
//  Arithmetic: none. Values pass bit-exact, sign preserved, no rounding/saturation.
//  i_valid beats need not be contiguous; gaps leave wr_row unchanged.
// TESTING
//  T1 reset: assert i_rst mid-run -> o_valid=0, o_overflow=0, o_col=0 immediately
//     (asynchronous, no clock edge needed).
//  T2 single block: 8 rows, i_dataK=r*8+K, i_ready=1 -> 8 beats,
//     beat c gives o_dataK=K*8+c (col0: 0,8,..,56), o_last only on c=7.
//  T3 backpressure: drop i_ready for 3 cycles at o_col=3 -> o_col/o_data held 3
//     cycles, then cols 4..7 output, no loss.
//  T4 back-to-back: 16 rows on consecutive cycles, i_ready=1 -> 16 column beats
//     in order, two o_last pulses, o_overflow=0.
//  T5 overflow: i_ready=0, 24 rows -> o_overflow=1 after 17th row, rows 17..24
//     dropped; raise i_ready -> blocks 1 and 2 exact.
//  T6 extremes: rows of -2048/+2047 alternating -> identical signed values out.
//  T7 reset after 4 rows of a block, then 8 fresh rows -> one block of only fresh data.

Source files
------------

// File: rtl/dct_transpose_buffer.sv
// Ping-pong 8x8 transpose buffer: rows are written into one bank while the
// other bank is read out column by column.
module dct_transpose_buffer #(
    parameter int unsigned DATA_W = 12
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data0,
    input  logic [DATA_W-1:0] i_data1,
    input  logic [DATA_W-1:0] i_data2,
    input  logic [DATA_W-1:0] i_data3,
    input  logic [DATA_W-1:0] i_data4,
    input  logic [DATA_W-1:0] i_data5,
    input  logic [DATA_W-1:0] i_data6,
    input  logic [DATA_W-1:0] i_data7,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data0,
    output logic [DATA_W-1:0] o_data1,
    output logic [DATA_W-1:0] o_data2,
    output logic [DATA_W-1:0] o_data3,
    output logic [DATA_W-1:0] o_data4,
    output logic [DATA_W-1:0] o_data5,
    output logic [DATA_W-1:0] o_data6,
    output logic [DATA_W-1:0] o_data7,
    output logic [2:0]        o_col,
    output logic              o_last,
    output logic              o_overflow
);

    typedef logic [DATA_W-1:0] coef_t;

    coef_t mem_q [2][8][8];
    coef_t mem_d [2][8][8];
    coef_t in_row [8];

    logic       wr_bank_q, wr_bank_d;
    logic       rd_bank_q, rd_bank_d;
    logic [2:0] wr_row_q, wr_row_d;
    logic [2:0] rd_col_q, rd_col_d;
    logic [1:0] full_q, full_d;
    logic       overflow_q, overflow_d;

    logic       rd_hs;
    logic       rd_done;
    logic       wr_ok;
    logic [1:0] full_after_rd;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < 8; r++) begin
                    for (int c = 0; c < 8; c++) begin
                        mem_q[b][r][c] <= '0;
                    end
                end
            end
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            wr_row_q   <= 3'd0;
            rd_col_q   <= 3'd0;
            full_q     <= 2'b00;
            overflow_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            wr_row_q   <= wr_row_d;
            rd_col_q   <= rd_col_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        in_row[0] = i_data0;
        in_row[1] = i_data1;
        in_row[2] = i_data2;
        in_row[3] = i_data3;
        in_row[4] = i_data4;
        in_row[5] = i_data5;
        in_row[6] = i_data6;
        in_row[7] = i_data7;

        mem_d      = mem_q;
        wr_bank_d  = wr_bank_q;
        rd_bank_d  = rd_bank_q;
        wr_row_d   = wr_row_q;
        rd_col_d   = rd_col_q;
        overflow_d = overflow_q;

        // Read side first so a bank released this cycle is writable this cycle.
        rd_hs         = full_q[rd_bank_q] && i_ready;
        rd_done       = rd_hs && (rd_col_q == 3'd7);
        full_after_rd = full_q;
        if (rd_hs) begin
            rd_col_d = rd_col_q + 3'd1;
        end
        if (rd_done) begin
            full_after_rd[rd_bank_q] = 1'b0;
            rd_bank_d                = ~rd_bank_q;
            rd_col_d                 = 3'd0;
        end

        full_d = full_after_rd;
        wr_ok  = i_valid && !full_after_rd[wr_bank_q];
        if (i_valid && !wr_ok) begin
            overflow_d = 1'b1;
        end
        if (wr_ok) begin
            for (int c = 0; c < 8; c++) begin
                mem_d[wr_bank_q][wr_row_q][c] = in_row[c];
            end
            wr_row_d = wr_row_q + 3'd1;
            if (wr_row_q == 3'd7) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
                wr_row_d          = 3'd0;
            end
        end
    end

    always_comb begin
        o_valid    = full_q[rd_bank_q];
        o_col      = rd_col_q;
        o_last     = full_q[rd_bank_q] && (rd_col_q == 3'd7);
        o_overflow = overflow_q;
        o_data0    = mem_q[rd_bank_q][0][rd_col_q];
        o_data1    = mem_q[rd_bank_q][1][rd_col_q];
        o_data2    = mem_q[rd_bank_q][2][rd_col_q];
        o_data3    = mem_q[rd_bank_q][3][rd_col_q];
        o_data4    = mem_q[rd_bank_q][4][rd_col_q];
        o_data5    = mem_q[rd_bank_q][5][rd_col_q];
        o_data6    = mem_q[rd_bank_q][6][rd_col_q];
        o_data7    = mem_q[rd_bank_q][7][rd_col_q];
    end

endmodule
